// File: rtl/tick_sched_pkg.sv
// Shared types and defaults for the tick scheduler: FSM state encoding and default sizing.
package tick_sched_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int PRESCALE_DEF = 50000;
  localparam int DIV_W_DEF    = 8;
endpackage

// File: rtl/tick_channel.sv
// One tick channel: divides the base pulse by div and emits a registered one-cycle tick.
module tick_channel #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;
  logic             wrap;

  // >= rather than == so a ratio lowered mid-count still wraps promptly
  assign wrap = (div != '0) && (cnt >= div - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= en && wrap;
      if (clr || (en && (wrap || div == '0)))
        cnt <= '0;
      else if (en)
        cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/tick_scheduler.sv
// Shared prescaler, run/pause FSM and config port feeding NCH tick channels.
// Optional ball speed-up ramp on channel 0 is built when SPEEDUP_EN is defined.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int PRESCALE    = PRESCALE_DEF,
  parameter int NCH         = 3,
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = 1,
  parameter int RAMP_HITS   = 4,
  parameter int MIN_DIV     = 2,
  localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             pause,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_err,
  input  logic             hit,
  output logic             tick_base,
  output logic [NCH-1:0]   tick,
  output logic [DIV_W-1:0] ball_div,
  output logic [1:0]       state
);
  localparam int PW = $clog2(PRESCALE);

  state_t                   st;
  logic [PW-1:0]            presc;
  logic [NCH-1:0][DIV_W-1:0] div;
  logic                     base;
  logic                     hold0;
  logic                     accept;
  logic                     ch_bad;
  logic [NCH-1:0]           ch_clr;

  assign state    = st;
  assign ball_div = div[0];
  assign base     = (st == RUN) && (presc == PW'(PRESCALE - 1));
  assign hold0    = !run || (st == IDLE);
  assign accept   = cfg_valid && cfg_ready;
  assign ch_bad   = ({1'b0, cfg_ch} >= (CH_W + 1)'(NCH));

  // cfg_ready is registered alongside the state so it tracks "not RUN"
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      cfg_ready <= 1'b1;
    end else if (!run) begin
      st        <= IDLE;
      cfg_ready <= 1'b1;
    end else begin
      case (st)
        IDLE: begin
          st        <= RUN;
          cfg_ready <= 1'b0;
        end
        RUN: if (pause) begin
          st        <= PAUSE;
          cfg_ready <= 1'b1;
        end
        PAUSE: if (!pause) begin
          st        <= RUN;
          cfg_ready <= 1'b0;
        end
        default: begin
          st        <= IDLE;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc     <= '0;
      tick_base <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      tick_base <= base;
      cfg_err   <= accept && ch_bad;
      if (hold0)
        presc <= '0;
      else if (st == RUN)
        presc <= base ? '0 : presc + 1'b1;
    end
  end

`ifdef SPEEDUP_EN
  localparam int HW = (RAMP_HITS > 1) ? $clog2(RAMP_HITS) : 1;

  logic [HW-1:0]    hit_cnt;
  logic [DIV_W-1:0] shadow;
  logic             enter_idle;
  logic             acc0;
  logic             step_dn;

  assign enter_idle = !run && (st != IDLE);
  assign acc0       = accept && (cfg_ch == '0);
  assign step_dn    = (st == RUN) && hit && (hit_cnt == HW'(RAMP_HITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt <= '0;
      shadow  <= DIV_W'(DEFAULT_DIV);
    end else begin
      if (acc0)
        shadow <= cfg_div;
      if (enter_idle || acc0)
        hit_cnt <= '0;
      else if ((st == RUN) && hit)
        hit_cnt <= step_dn ? '0 : hit_cnt + 1'b1;
    end
  end
`else
  logic unused_speedup;
  assign unused_speedup = &{1'b0, hit, RAMP_HITS[0], MIN_DIV[0]};
`endif

  // A config write is applied last so it wins over the idle restore
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++)
        div[i] <= DIV_W'(DEFAULT_DIV);
    end else begin
`ifdef SPEEDUP_EN
      if (enter_idle)
        div[0] <= shadow;
      else if (step_dn && (div[0] > DIV_W'(MIN_DIV)))
        div[0] <= div[0] - 1'b1;
`endif
      for (int i = 0; i < NCH; i++)
        if (accept && (cfg_ch == CH_W'(i)))
          div[i] <= cfg_div;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign ch_clr[g] = hold0 || (accept && (cfg_ch == CH_W'(g)));

    tick_channel #(.DIV_W(DIV_W)) u_ch (
      .clk  (clk),
      .rst  (rst),
      .en   (base),
      .clr  (ch_clr[g]),
      .div  (div[g]),
      .tick (tick[g])
    );
  end
endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: cycle-stepped reference model built from the rules (run-cycle and
// base-tick counts with modulo), compared against the DUT after every edge; SPEEDUP_EN adds a ramp test.
module tb_tick_scheduler;
  localparam int P    = 4;
  localparam int N    = 3;
  localparam int RAMP = 4;
  localparam int MIN  = 2;

  logic       clk = 1'b0;
  logic       rst, run, pause, cfg_valid, hit;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic       cfg_ready, cfg_err, tick_base;
  logic [2:0] tick;
  logic [7:0] ball_div;
  logic [1:0] state;
  logic [15:0] got;

  int total = 0;
  int bad   = 0;

  // reference model
  int       m_st, m_rc, m_h, m_sh;
  int       m_nb[N];
  int       m_div[N];
  bit       m_tb, m_err;
  bit [2:0] m_tick;

  tick_scheduler #(
    .PRESCALE(P), .NCH(N), .DIV_W(8), .DEFAULT_DIV(1), .RAMP_HITS(RAMP), .MIN_DIV(MIN)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .pause(pause),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_err(cfg_err), .hit(hit), .tick_base(tick_base), .tick(tick),
    .ball_div(ball_div), .state(state)
  );

  always #5 clk = ~clk;

  assign got = {state, tick_base, tick, cfg_err, cfg_ready, ball_div};

  function automatic logic [15:0] exp_vec();
    return {2'(m_st), m_tb, m_tick, m_err, (m_st != 1), 8'(m_div[0])};
  endfunction

  task automatic model_reset();
    m_st = 0; m_rc = 0; m_h = 0; m_sh = 1;
    m_tb = 0; m_err = 0; m_tick = '0;
    for (int i = 0; i < N; i++) begin m_nb[i] = 0; m_div[i] = 1; end
  endtask

  task automatic model_cycle(input bit r, input bit p, input bit v, input int ch, input int d,
                             input bit h);
    bit b, acc;
    b = (m_st == 1) && ((m_rc % P) == P - 1);
    m_tb = b;
    for (int i = 0; i < N; i++) begin
      m_tick[i] = 1'b0;
      if (b && m_div[i] != 0)
        m_tick[i] = ((m_nb[i] % m_div[i]) == m_div[i] - 1);
    end
    acc   = v && (m_st != 1);
    m_err = acc && (ch >= N);
    if (!r || m_st == 0) begin
      m_rc = 0;
      for (int i = 0; i < N; i++) m_nb[i] = 0;
    end else if (m_st == 1) begin
      m_rc++;
      if (b) for (int i = 0; i < N; i++) m_nb[i]++;
    end
`ifdef SPEEDUP_EN
    if (!r && m_st != 0) begin
      m_div[0] = m_sh; m_h = 0;
    end else if (m_st == 1 && h) begin
      m_h++;
      if (m_h == RAMP) begin
        m_h = 0;
        if (m_div[0] > MIN) m_div[0]--;
      end
    end
    if (acc && ch == 0) begin m_sh = d; m_h = 0; end
`endif
    if (acc && ch < N) begin m_div[ch] = d; m_nb[ch] = 0; end
    if (!r) m_st = 0;
    else if (m_st == 0) m_st = 1;
    else if (m_st == 1 && p) m_st = 2;
    else if (m_st == 2 && !p) m_st = 1;
  endtask

  // advance DUT and model by one edge; outputs are sampled 1 ns after the edge
  task automatic step();
    bit r_rst = rst, r_run = run, r_p = pause, r_v = cfg_valid, r_h = hit;
    int r_ch = int'(cfg_ch), r_d = int'(cfg_div);
    @(posedge clk);
    #1;
    if (r_rst) model_reset();
    else model_cycle(r_run, r_p, r_v, r_ch, r_d, r_h);
  endtask

  task automatic test_reset();
    rst = 1; run = 1; pause = 0; cfg_valid = 0; cfg_ch = 0; cfg_div = 0; hit = 0;
    for (int i = 0; i < 2; i++) begin
      step(); total++;
      if (got !== exp_vec()) begin bad++; $display("FAIL reset got=%h exp=%h", got, exp_vec()); end
    end
    total++;
    if ({state, cfg_ready, tick_base, tick, ball_div} !== {2'd0, 1'b1, 1'b0, 3'b000, 8'd1}) begin
      bad++; $display("FAIL reset_values got=%h", {state, cfg_ready, tick_base, tick, ball_div});
    end
    rst = 0; run = 0;
    step();
  endtask

  task automatic test_basic();
    int first = -1;
    run = 1;
    for (int k = 1; k <= 20; k++) begin
      step(); total++;
      if (got !== exp_vec()) begin bad++; $display("FAIL basic k=%0d got=%h exp=%h", k, got, exp_vec()); end
      if (first < 0 && tick_base) first = k;
    end
    total++;
    if (first != 5) begin bad++; $display("FAIL first_tick got=%0d exp=5", first); end
  endtask

  task automatic test_cfg_div();
    int n1 = 0;
    run = 0; step();
    cfg_valid = 1; cfg_ch = 1; cfg_div = 3;
    step(); total++;
    if (got !== exp_vec()) begin bad++; $display("FAIL cfg_accept got=%h exp=%h", got, exp_vec()); end
    cfg_valid = 0; run = 1;
    for (int k = 1; k <= 40; k++) begin
      step(); total++;
      if (got !== exp_vec()) begin bad++; $display("FAIL cfg_div k=%0d got=%h exp=%h", k, got, exp_vec()); end
      if (tick[1]) n1++;
    end
    total++;
    if (n1 != 3) begin bad++; $display("FAIL tick1_count got=%0d exp=3", n1); end
  endtask

  task automatic test_pause();
    int nb = 0;
    repeat ($urandom_range(1, 7)) begin
      step(); total++;
      if (got !== exp_vec()) begin bad++; $display("FAIL pre_pause got=%h exp=%h", got, exp_vec()); end
    end
    pause = 1;
    for (int k = 1; k <= 10; k++) begin
      step(); total++;
      if (got !== exp_vec()) begin bad++; $display("FAIL pause k=%0d got=%h exp=%h", k, got, exp_vec()); end
      if (k > 1 && (tick_base || tick != 0 || state != 2'd2)) nb++;
    end
    total++;
    if (nb != 0) begin bad++; $display("FAIL pause_quiet got=%0d exp=0", nb); end
    pause = 0;
    for (int k = 1; k <= 16; k++) begin
      step(); total++;
      if (got !== exp_vec()) begin bad++; $display("FAIL resume k=%0d got=%h exp=%h", k, got, exp_vec()); end
    end
  endtask

  task automatic test_cfg_hold();
    cfg_valid = 1; cfg_ch = 2; cfg_div = 2;
    for (int k = 1; k <= 5; k++) begin
      step(); total++;
      if (got !== exp_vec()) begin bad++; $display("FAIL hold_run k=%0d got=%h exp=%h", k, got, exp_vec()); end
    end
    pause = 1;
    for (int k = 1; k <= 2; k++) begin
      step(); total++;
      if (got !== exp_vec()) begin bad++; $display("FAIL hold_pause k=%0d got=%h exp=%h", k, got, exp_vec()); end
    end
    cfg_ch = 3; cfg_div = 7;
    step(); total++;
    if (cfg_err !== 1'b1 || got !== exp_vec()) begin
      bad++; $display("FAIL cfg_err got=%h exp=%h", got, exp_vec());
    end
    cfg_valid = 0;
    step(); total++;
    if (cfg_err !== 1'b0) begin bad++; $display("FAIL cfg_err_pulse got=%b exp=0", cfg_err); end
    pause = 0;
    for (int k = 1; k <= 24; k++) begin
      step(); total++;
      if (got !== exp_vec()) begin bad++; $display("FAIL post_cfg k=%0d got=%h exp=%h", k, got, exp_vec()); end
    end
  endtask

  task automatic test_disable();
    int n2 = 0;
    pause = 1; step(); step();
    cfg_valid = 1; cfg_ch = 2; cfg_div = 0;
    step(); cfg_valid = 0; pause = 0;
    for (int k = 1; k <= 20; k++) begin
      step(); total++;
      if (got !== exp_vec()) begin bad++; $display("FAIL disable k=%0d got=%h exp=%h", k, got, exp_vec()); end
      if (tick[2]) n2++;
    end
    total++;
    if (n2 != 0) begin bad++; $display("FAIL tick2_off got=%0d exp=0", n2); end
    run = 0; step(); total++;
    if (got !== exp_vec() || state !== 2'd0) begin
      bad++; $display("FAIL stop got=%h exp=%h", got, exp_vec());
    end
    run = 1;
    for (int k = 1; k <= 7; k++) begin
      step(); total++;
      if (got !== exp_vec()) begin bad++; $display("FAIL restart k=%0d got=%h exp=%h", k, got, exp_vec()); end
    end
    rst = 1; step(); rst = 0; total++;
    if (got !== exp_vec() || ball_div !== 8'd1) begin
      bad++; $display("FAIL mid_rst got=%h exp=%h", got, exp_vec());
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      run       = ($urandom_range(0, 19) != 0);
      pause     = ($urandom_range(0, 5) == 0);
      cfg_valid = ($urandom_range(0, 4) == 0);
      cfg_ch    = 2'($urandom_range(0, 3));
      cfg_div   = 8'($urandom_range(0, 4));
      step(); total++;
      if (got !== exp_vec()) begin bad++; $display("FAIL random k=%0d got=%h exp=%h", k, got, exp_vec()); end
    end
    cfg_valid = 0; pause = 0;
  endtask

`ifdef SPEEDUP_EN
  task automatic pulse_hit();
    hit = 1; step(); hit = 0; step();
  endtask

  task automatic test_speedup();
    rst = 1; step(); rst = 0; run = 0; step();
    cfg_valid = 1; cfg_ch = 0; cfg_div = 6; step(); cfg_valid = 0;
    run = 1; step();
    for (int n = 1; n <= 20; n++) begin
      pulse_hit();
      if (n == 4 || n == 16 || n == 20) begin
        total++;
        if (ball_div !== 8'((n == 4) ? 5 : 2) || ball_div !== 8'(m_div[0])) begin
          bad++; $display("FAIL ramp hits=%0d got=%0d exp=%0d", n, ball_div, (n == 4) ? 5 : 2);
        end
      end
    end
    run = 0; step(); total++;
    if (ball_div !== 8'd6) begin bad++; $display("FAIL restore got=%0d exp=6", ball_div); end
    run = 1; step(); pause = 1; step();
    repeat (4) pulse_hit();
    pause = 0; step();
    repeat (3) pulse_hit();
    total++;
    if (ball_div !== 8'd6) begin bad++; $display("FAIL pause_hits got=%0d exp=6", ball_div); end
    pulse_hit(); total++;
    if (ball_div !== 8'd5 || ball_div !== 8'(m_div[0])) begin
      bad++; $display("FAIL ramp_after_pause got=%0d exp=5", ball_div);
    end
    run = 0; step();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_cfg_div();
    test_pause();
    test_cfg_hold();
    test_disable();
    test_random();
`ifdef SPEEDUP_EN
    test_speedup();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
